// File: rtl/inst_loop_ctrl_nested.sv
// N-level nested loop controller: odometer-style counters that drive PC jump requests.
// Define INST_LOOP_CTRL_STATUS_EN to add live-counter and jump-total readback ports.
module inst_loop_ctrl_nested #(
  parameter int unsigned InstMemAddrWidth = 32,
  parameter int unsigned NumLoops         = 4,
  parameter int unsigned LoopCountWidth   = 16,
  parameter int unsigned LoopDepthWidth   = $clog2(NumLoops + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clr_i,
  input  logic                                 en_i,
  input  logic                                 stall_i,
  input  logic                                 dbg_en_i,
  input  logic [InstMemAddrWidth-1:0]          inst_pc_i,
  input  logic [LoopDepthWidth-1:0]            loop_depth_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] loop_jump_addr_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] loop_end_addr_i,
  input  logic [NumLoops*LoopCountWidth-1:0]   loop_count_i,
  output logic                                 inst_jump_o,
  output logic [InstMemAddrWidth-1:0]          inst_jump_addr_o,
  output logic                                 inst_loop_done_o,
  output logic                                 loop_busy_o
`ifdef INST_LOOP_CTRL_STATUS_EN
  ,
  output logic [NumLoops*LoopCountWidth-1:0]   loop_count_o,
  output logic [31:0]                          loop_iter_total_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                                  state_q, state_d;
  logic [NumLoops-1:0][LoopCountWidth-1:0] cnt_q, cnt_d;

  logic [NumLoops-1:0]         active, hit, bound, reach, carry;
  logic                        lower_hit, chain_c, done_carry, jump_any;
  logic [LoopCountWidth-1:0]   cnt_last;
  logic [InstMemAddrWidth-1:0] jump_tgt;
  logic                        adv, done;

  // Carry chain walks from the innermost level outward; a hit with no hit below it
  // starts its own chain, otherwise it only advances on the carry from below.
  always_comb begin
    active     = '0;
    hit        = '0;
    bound      = '0;
    reach      = '0;
    carry      = '0;
    lower_hit  = 1'b0;
    chain_c    = 1'b1;
    done_carry = 1'b0;
    jump_any   = 1'b0;
    jump_tgt   = '0;
    cnt_last   = '0;
    for (int k = 0; k < int'(NumLoops); k++) begin
      active[k] = k < int'(loop_depth_i);
      hit[k]    = active[k] &&
                  (inst_pc_i == loop_end_addr_i[k*InstMemAddrWidth +: InstMemAddrWidth]);
      cnt_last  = loop_count_i[k*LoopCountWidth +: LoopCountWidth] - LoopCountWidth'(1);
      if (loop_count_i[k*LoopCountWidth +: LoopCountWidth] == '0) begin
        cnt_last = '0;
      end
      bound[k] = (cnt_q[k] == cnt_last);
      reach[k] = hit[k] && (!lower_hit || chain_c);
      carry[k] = reach[k] && bound[k];
      if (reach[k] && !bound[k] && !jump_any) begin
        jump_any = 1'b1;
        jump_tgt = loop_jump_addr_i[k*InstMemAddrWidth +: InstMemAddrWidth];
      end
      // Ends up holding the carry out of the outermost active level.
      if (active[k]) begin
        done_carry = carry[k];
      end
      lower_hit = lower_hit || hit[k];
      chain_c   = carry[k];
    end
  end

  assign adv = en_i && !stall_i && !dbg_en_i && !clr_i && (state_q == StRun);
  assign done = adv && done_carry;

  assign inst_jump_o      = adv && jump_any && !done;
  assign inst_jump_addr_o = inst_jump_o ? jump_tgt : '0;
  assign inst_loop_done_o = done;
  assign loop_busy_o      = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      if (!stall_i && !dbg_en_i) begin
        unique case (state_q)
          StIdle: if (en_i && loop_depth_i != '0) state_d = StRun;
          StRun: begin
            if (!en_i) begin
              state_d = StIdle;
            end else if (done) begin
              state_d = StDone;
            end
          end
          StDone:  if (!en_i) state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
      if (done) begin
        cnt_d = '0;
      end else if (adv) begin
        for (int k = 0; k < int'(NumLoops); k++) begin
          if (reach[k]) begin
            cnt_d[k] = bound[k] ? '0 : cnt_q[k] + LoopCountWidth'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef INST_LOOP_CTRL_STATUS_EN
  logic [31:0] iter_total_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_total_q <= '0;
    end else if (clr_i) begin
      iter_total_q <= '0;
    end else if (inst_jump_o && iter_total_q != '1) begin
      iter_total_q <= iter_total_q + 32'd1;
    end
  end

  assign loop_count_o      = cnt_q;
  assign loop_iter_total_o = iter_total_q;
`endif

endmodule

// File: tb/tb_inst_loop_ctrl_nested.sv
// Bench for inst_loop_ctrl_nested: directed loop programs plus randomized nests,
// checked every cycle against an odometer-style reference model.
module tb_inst_loop_ctrl_nested;
  localparam int AW = 32;
  localparam int NL = 4;
  localparam int CW = 16;
  localparam int DW = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni, clr_i, en_i, stall_i, dbg_en_i;
  logic [AW-1:0]    inst_pc_i;
  logic [DW-1:0]    loop_depth_i;
  logic [NL*AW-1:0] loop_jump_addr_i, loop_end_addr_i;
  logic [NL*CW-1:0] loop_count_i;
  logic             inst_jump_o, inst_loop_done_o, loop_busy_o;
  logic [AW-1:0]    inst_jump_addr_o;
`ifdef INST_LOOP_CTRL_STATUS_EN
  logic [NL*CW-1:0] loop_count_o;
  logic [31:0]      loop_iter_total_o;
`endif

  always #5 clk_i = ~clk_i;

  inst_loop_ctrl_nested dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clr_i            (clr_i),
    .en_i             (en_i),
    .stall_i          (stall_i),
    .dbg_en_i         (dbg_en_i),
    .inst_pc_i        (inst_pc_i),
    .loop_depth_i     (loop_depth_i),
    .loop_jump_addr_i (loop_jump_addr_i),
    .loop_end_addr_i  (loop_end_addr_i),
    .loop_count_i     (loop_count_i),
    .inst_jump_o      (inst_jump_o),
    .inst_jump_addr_o (inst_jump_addr_o),
    .inst_loop_done_o (inst_loop_done_o),
    .loop_busy_o      (loop_busy_o)
`ifdef INST_LOOP_CTRL_STATUS_EN
    ,
    .loop_count_o     (loop_count_o),
    .loop_iter_total_o(loop_iter_total_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  string phase = "rst";

  logic [AW-1:0] c_jump[NL];
  logic [AW-1:0] c_end[NL];
  logic [CW-1:0] c_cnt[NL];

  // Reference model state: counters, FSM (0 idle, 1 run, 2 done), jump total.
  logic [CW-1:0] m_cnt[NL];
  logic [CW-1:0] n_cnt[NL];
  int            m_st, n_st;
  logic [31:0]   m_total;
  logic          e_jump, e_done;
  logic [AW-1:0] e_addr;

  logic [AW-1:0] obs_q[$];
  logic [AW-1:0] exp_q[$];
  int            n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cfg();
    for (int k = 0; k < NL; k++) begin
      loop_jump_addr_i[k*AW +: AW] = c_jump[k];
      loop_end_addr_i[k*AW +: AW]  = c_end[k];
      loop_count_i[k*CW +: CW]     = c_cnt[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NL; k++) m_cnt[k] = '0;
    m_st    = 0;
    m_total = '0;
  endtask

  // Odometer view: the lowest hitting level ticks; on wrap it passes the tick to the
  // next level only if that level also sits on this PC. Wrapping the top level ends the nest.
  task automatic model_eval();
    int   ed, lo, k;
    bit   adv, stop;
    logic [CW-1:0] lim;
    ed     = (int'(loop_depth_i) > NL) ? NL : int'(loop_depth_i);
    adv    = en_i && !stall_i && !dbg_en_i && !clr_i && (m_st == 1);
    e_jump = 1'b0;
    e_done = 1'b0;
    e_addr = '0;
    for (int j = 0; j < NL; j++) n_cnt[j] = m_cnt[j];
    n_st = m_st;
    if (adv) begin
      lo = -1;
      for (int j = ed - 1; j >= 0; j--) if (inst_pc_i == c_end[j]) lo = j;
      if (lo >= 0) begin
        k    = lo;
        stop = 1'b0;
        for (int s = 0; s < NL && !stop; s++) begin
          lim = (c_cnt[k] == '0) ? '0 : c_cnt[k] - 16'd1;
          if (m_cnt[k] != lim) begin
            n_cnt[k] = m_cnt[k] + 16'd1;
            e_jump   = 1'b1;
            e_addr   = c_jump[k];
            stop     = 1'b1;
          end else begin
            n_cnt[k] = '0;
            if (k == ed - 1) begin
              e_done = 1'b1;
              stop   = 1'b1;
            end else begin
              k++;
              if (inst_pc_i != c_end[k]) stop = 1'b1;
            end
          end
        end
      end
      if (e_done) for (int j = 0; j < NL; j++) n_cnt[j] = '0;
    end
    if (clr_i) begin
      n_st = 0;
      for (int j = 0; j < NL; j++) n_cnt[j] = '0;
    end else if (!stall_i && !dbg_en_i) begin
      case (m_st)
        0:       if (en_i && loop_depth_i != '0) n_st = 1;
        1:       if (!en_i) n_st = 0; else if (e_done) n_st = 2;
        default: if (!en_i) n_st = 0;
      endcase
    end
  endtask

  // Called at posedge+1 with inputs driven; samples at the falling edge.
  task automatic step();
    #4;
    model_eval();
    chk({phase, "/jump"}, 32'(inst_jump_o), 32'(e_jump));
    chk({phase, "/addr"}, inst_jump_addr_o, e_addr);
    chk({phase, "/done"}, 32'(inst_loop_done_o), 32'(e_done));
    chk({phase, "/busy"}, 32'(loop_busy_o), 32'(m_st == 1));
`ifdef INST_LOOP_CTRL_STATUS_EN
    for (int k = 0; k < NL; k++) chk({phase, "/cnt"}, 32'(loop_count_o[k*CW +: CW]), 32'(m_cnt[k]));
    chk({phase, "/total"}, loop_iter_total_o, m_total);
`endif
    if (inst_jump_o) obs_q.push_back(inst_jump_addr_o);
    if (inst_loop_done_o) n_done++;
    for (int k = 0; k < NL; k++) m_cnt[k] = n_cnt[k];
    m_st = n_st;
    if (clr_i) m_total = '0;
    else if (e_jump && m_total != '1) m_total = m_total + 32'd1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_clear();
    en_i     = 1'b0;
    stall_i  = 1'b0;
    dbg_en_i = 1'b0;
    clr_i    = 1'b1;
    step();
    clr_i = 1'b0;
    step();
    obs_q.delete();
    n_done = 0;
  endtask

  // Runs a program from PC 0, following the model's jumps, until the nest completes.
  task automatic run_prog(input int budget, input int stall_pct, input int clr_pm);
    int pc;
    bit fin;
    pc  = 0;
    fin = 1'b0;
    en_i = 1'b1;
    for (int n = 0; n < budget && !fin; n++) begin
      inst_pc_i = 32'(pc);
      stall_i   = ($urandom_range(0, 99) < stall_pct);
      dbg_en_i  = ($urandom_range(0, 199) < stall_pct);
      clr_i     = ($urandom_range(0, 999) < clr_pm);
      step();
      if (e_jump) pc = int'(e_addr);
      else if (!stall_i && !dbg_en_i) pc++;
      if (m_st == 2) fin = 1'b1;
    end
    stall_i  = 1'b0;
    dbg_en_i = 1'b0;
    clr_i    = 1'b0;
    chk({phase, "/finished"}, 32'(fin), 32'd1);
    step();
  endtask

  task automatic chk_seq();
    chk({phase, "/njumps"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({phase, "/seq"}, obs_q[i], exp_q[i]);
    end
    chk({phase, "/ndone"}, 32'(n_done), 32'd1);
  endtask

  task automatic cfg_clear();
    for (int k = 0; k < NL; k++) begin
      c_jump[k] = '0;
      c_end[k]  = 32'hFFFF_0000 + 32'(k);
      c_cnt[k]  = '0;
    end
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; en_i = 1'b0; stall_i = 1'b0; dbg_en_i = 1'b0;
    inst_pc_i = '0; loop_depth_i = '0;
    cfg_clear();
    drive_cfg();
    model_reset();
    n_done = 0;
    #2;
    chk("rst/jump", 32'(inst_jump_o), 32'd0);
    chk("rst/addr", inst_jump_addr_o, 32'd0);
    chk("rst/done", 32'(inst_loop_done_o), 32'd0);
    chk("rst/busy", 32'(loop_busy_o), 32'd0);
    #11 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single loop: two jumps then done on the third hit.
    phase = "t1";
    cfg_clear();
    loop_depth_i = 3'd1; c_end[0] = 32'd8; c_jump[0] = 32'd2; c_cnt[0] = 16'd3;
    drive_cfg();
    idle_clear();
    run_prog(200, 0, 0);
    exp_q.delete(); exp_q.push_back(32'd2); exp_q.push_back(32'd2);
    chk_seq();
    chk("t1/busy_after", 32'(loop_busy_o), 32'd0);

    // Two levels sharing one end address.
    phase = "t2";
    cfg_clear();
    loop_depth_i = 3'd2; c_end[0] = 32'd8; c_end[1] = 32'd8;
    c_jump[0] = 32'd4; c_jump[1] = 32'd2; c_cnt[0] = 16'd2; c_cnt[1] = 16'd3;
    drive_cfg();
    idle_clear();
    run_prog(200, 0, 0);
    exp_q.delete();
    exp_q.push_back(32'd4); exp_q.push_back(32'd2); exp_q.push_back(32'd4);
    exp_q.push_back(32'd2); exp_q.push_back(32'd4);
    chk_seq();

    // Three levels with distinct ends.
    phase = "t3";
    cfg_clear();
    loop_depth_i = 3'd3; c_end[0] = 32'd5; c_end[1] = 32'd9; c_end[2] = 32'd12;
    c_jump[0] = 32'd3; c_jump[1] = 32'd2; c_jump[2] = 32'd1;
    c_cnt[0] = 16'd2; c_cnt[1] = 16'd2; c_cnt[2] = 16'd2;
    drive_cfg();
    idle_clear();
    run_prog(300, 0, 0);
    exp_q.delete();
    exp_q.push_back(32'd3); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    chk_seq();

    // Stall while sitting on the end address.
    phase = "t4";
    cfg_clear();
    loop_depth_i = 3'd1; c_end[0] = 32'd8; c_jump[0] = 32'd2; c_cnt[0] = 16'd3;
    drive_cfg();
    idle_clear();
    en_i = 1'b1; inst_pc_i = 32'd0;
    step();
    inst_pc_i = 32'd8;
    step();
    stall_i = 1'b1;
    step();
    chk("t4/stall_jump", 32'(inst_jump_o), 32'd0);
    stall_i = 1'b0; dbg_en_i = 1'b1;
    step();
    dbg_en_i = 1'b0;
    #4;
    chk("t4/release_jump", 32'(inst_jump_o), 32'd1);
    #1;
    @(posedge clk_i);
    #0;
    // Re-sync the model with the extra cycle taken above.
    phase = "t4b";
    idle_clear();
    en_i = 1'b1; inst_pc_i = 32'd0;
    step();
    inst_pc_i = 32'd8;
    step();
    stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    step();
    step();
    chk("t4b/done_after_3", 32'(n_done), 32'd1);

    // count0 = 0 behaves as one pass; clear and async reset mid-run.
    phase = "t5";
    cfg_clear();
    loop_depth_i = 3'd1; c_end[0] = 32'd8; c_jump[0] = 32'd2; c_cnt[0] = 16'd0;
    drive_cfg();
    idle_clear();
    en_i = 1'b1; inst_pc_i = 32'd8;
    step();
    step();
    chk("t5/done_zero_count", 32'(n_done), 32'd1);
    c_cnt[0] = 16'd3;
    drive_cfg();
    en_i = 1'b0;
    step();
    en_i = 1'b1;
    step();
    step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t5/busy_after_clr", 32'(loop_busy_o), 32'd0);
    step();
    step();
    rst_ni = 1'b0;
    #1;
    chk("t5/arst_busy", 32'(loop_busy_o), 32'd0);
    chk("t5/arst_jump", 32'(inst_jump_o), 32'd0);
    model_reset();
    rst_ni = 1'b1;
    step();
    step();

    // Depth zero never starts.
    phase = "t6";
    cfg_clear();
    loop_depth_i = 3'd0;
    for (int k = 0; k < NL; k++) begin
      c_end[k] = 32'(4 + k); c_jump[k] = 32'd1; c_cnt[k] = 16'd2;
    end
    drive_cfg();
    idle_clear();
    en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inst_pc_i = 32'($urandom_range(0, 9));
      step();
    end
    chk("t6/busy", 32'(loop_busy_o), 32'd0);
    chk("t6/njumps", 32'(obs_q.size()), 32'd0);

    // Random nests with random stalls, debug holds and occasional clears.
    for (int r = 0; r < 20; r++) begin
      phase = $sformatf("rnd%0d", r);
      cfg_clear();
      loop_depth_i = 3'($urandom_range(1, 4));
      for (int k = 0; k < NL; k++) begin
        c_jump[k] = 32'(10 - 2 * k);
        c_cnt[k]  = 16'($urandom_range(0, 3));
        if (k == 0) c_end[k] = 32'(12 + $urandom_range(0, 3));
        else c_end[k] = c_end[k-1] + (($urandom_range(0, 2) == 0) ? 32'd0
                                                                  : 32'($urandom_range(1, 3)));
      end
      drive_cfg();
      idle_clear();
      run_prog(6000, 10, (r % 4 == 0) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
